// File: rtl/pipe_pkg.sv
// Shared state encoding, NOP bubble and occupancy helper for the pipeline stage register.
package pipe_pkg;

    localparam int unsigned MAX_WIDTH = 32'd512;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // A flushed slot reads as an all-zero NOP; narrower payloads take the low bits.
    localparam logic [MAX_WIDTH-1:0] BUBBLE = {MAX_WIDTH{1'b0}};

    function automatic logic [1:0] occ_of(input state_t s);
        logic [1:0] occ;
        case (s)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_TWO:   occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake, payload and pipeline control bundle between a producer and one stage register.
interface pipe_stage_reg_if #(
    parameter int unsigned WIDTH = 32'd32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic             freeze;

    modport master (
        output in_valid, in_data, out_ready, flush, freeze,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush, freeze,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_slot.sv
// One payload slot: load-enabled register with a synchronous clear to the NOP bubble.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32'd32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Slot storage; clear dominates load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= BUBBLE[WIDTH-1:0];
        end else if (clr) begin
            q <= BUBBLE[WIDTH-1:0];
        end else if (ld) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional skid slot, flush/freeze control and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32'd32,
    parameter int unsigned SKID  = 32'd1,
    parameter int unsigned CNT_W = 32'd16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_reg_if.slave  bus,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_r;
    state_t           state_s;
    logic             in_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             stall_inc_s;
    logic             main_ld_s;
    logic             skid_ld_s;
    logic             main_sel_skid_s;
    logic [WIDTH-1:0] main_d_s;
    logic [WIDTH-1:0] main_q_s;
    logic [WIDTH-1:0] skid_q_s;
    logic [CNT_W-1:0] stall_r;

    // Ready: with a skid slot it depends only on registered state, otherwise it passes out_ready through.
    always_comb begin
        in_ready_s = 1'b0;
        if (bus.freeze || bus.flush) begin
            in_ready_s = 1'b0;
        end else if (SKID != 32'd0) begin
            in_ready_s = (state_r != ST_TWO);
        end else begin
            in_ready_s = (state_r == ST_EMPTY) || bus.out_ready;
        end
    end

    assign push_s      = bus.in_valid & in_ready_s;
    assign pop_s       = (state_r != ST_EMPTY) & bus.out_ready & ~bus.freeze & ~bus.flush;
    assign stall_inc_s = (state_r != ST_EMPTY) & (~bus.out_ready | bus.freeze) & ~bus.flush;

    // Next-state and slot steering; flush wins over everything else.
    always_comb begin
        state_s         = state_r;
        main_ld_s       = 1'b0;
        skid_ld_s       = 1'b0;
        main_sel_skid_s = 1'b0;
        if (bus.flush) begin
            state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_s   = ST_ONE;
                        main_ld_s = 1'b1;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        state_s   = ST_ONE;
                        main_ld_s = 1'b1;
                    end else if (pop_s) begin
                        state_s = ST_EMPTY;
                    end else if (push_s && (SKID != 32'd0)) begin
                        state_s   = ST_TWO;
                        skid_ld_s = 1'b1;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // The skid entry is the next-oldest, so it moves into the head slot.
                    if (pop_s) begin
                        state_s         = ST_ONE;
                        main_ld_s       = 1'b1;
                        main_sel_skid_s = 1'b1;
                    end else begin
                        state_s = ST_TWO;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Saturating stall counter; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_r <= {CNT_W{1'b0}};
        end else if (stall_inc_s && (stall_r != CNT_MAX)) begin
            stall_r <= stall_r + CNT_W'(1);
        end else begin
            stall_r <= stall_r;
        end
    end

    assign main_d_s = main_sel_skid_s ? skid_q_s : bus.in_data;

    pipe_slot #(.WIDTH(WIDTH)) u_main (
        .clk (clk),
        .rst (rst),
        .ld  (main_ld_s),
        .clr (bus.flush),
        .d   (main_d_s),
        .q   (main_q_s)
    );

    generate
        if (SKID != 32'd0) begin : g_skid
            pipe_slot #(.WIDTH(WIDTH)) u_skid (
                .clk (clk),
                .rst (rst),
                .ld  (skid_ld_s),
                .clr (bus.flush),
                .d   (bus.in_data),
                .q   (skid_q_s)
            );
        end else begin : g_no_skid
            assign skid_q_s = {WIDTH{1'b0}};
        end
    endgenerate

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_r != ST_EMPTY);
    assign bus.out_data  = main_q_s;
    assign occupancy     = occ_of(state_r);
    assign stall_cnt     = stall_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: a skid stage (CNT_W=4) and a pass-through stage (SKID=0) share one stimulus stream.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, out_ready, flush, freeze;
    logic [31:0] in_data;

    pipe_stage_reg_if #(.WIDTH(32)) bus_a ();
    pipe_stage_reg_if #(.WIDTH(32)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_data   = in_data;
    assign bus_a.out_ready = out_ready;
    assign bus_a.flush     = flush;
    assign bus_a.freeze    = freeze;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_data   = in_data;
    assign bus_b.out_ready = out_ready;
    assign bus_b.flush     = flush;
    assign bus_b.freeze    = freeze;

    logic [1:0]  occ_a, occ_b;
    logic [3:0]  stall_a;
    logic [15:0] stall_b;

    pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .occupancy(occ_a), .stall_cnt(stall_a)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(0), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .occupancy(occ_b), .stall_cnt(stall_b)
    );

    logic        dut_ready [2];
    logic        dut_valid [2];
    logic [31:0] dut_data  [2];
    logic [1:0]  dut_occ   [2];
    logic [15:0] dut_stall [2];

    assign dut_ready[0] = bus_a.in_ready;
    assign dut_ready[1] = bus_b.in_ready;
    assign dut_valid[0] = bus_a.out_valid;
    assign dut_valid[1] = bus_b.out_valid;
    assign dut_data[0]  = bus_a.out_data;
    assign dut_data[1]  = bus_b.out_data;
    assign dut_occ[0]   = occ_a;
    assign dut_occ[1]   = occ_b;
    assign dut_stall[0] = {12'd0, stall_a};
    assign dut_stall[1] = stall_b;

    // Reference model: entry count per stage, stall count, and whether the head slot is a bubble.
    int  m_cnt[2];
    int  m_stall[2];
    bit  m_bubble[2];
    int  cap[2];
    int  stall_max[2];

    logic exp_ready[2];
    logic exp_valid[2];
    int   exp_occ[2];
    int   exp_stall[2];
    bit   exp_bubble[2];

    logic [31:0] sb_mem[2][64];
    int          sb_wr[2];
    int          sb_rd[2];

    int tests = 0;
    int fails = 0;
    bit run   = 1'b0;

    function automatic void check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, i, act, exp);
        end
    endfunction

    // One clock of stimulus: predict this cycle's outputs, queue accepted payloads, then advance the model.
    task automatic step(input logic iv, input logic [31:0] d, input logic orr, input logic fl, input logic fz);
        bit push_e[2];
        bit pop_e[2];
        in_valid = iv; in_data = d; out_ready = orr; flush = fl; freeze = fz;
        for (int i = 0; i < 2; i++) begin
            exp_valid[i]  = (m_cnt[i] != 0);
            exp_ready[i]  = !fl && !fz && ((cap[i] == 2) ? (m_cnt[i] < 2) : (m_cnt[i] == 0 || orr));
            exp_occ[i]    = m_cnt[i];
            exp_stall[i]  = m_stall[i];
            exp_bubble[i] = m_bubble[i];
            push_e[i]     = iv && exp_ready[i];
            pop_e[i]      = exp_valid[i] && orr && !fz && !fl;
            if (push_e[i]) begin
                sb_mem[i][sb_wr[i] % 64] = d;
                sb_wr[i]++;
            end
            if (fl) sb_rd[i] = sb_wr[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (exp_valid[i] && (!orr || fz) && !fl && (m_stall[i] < stall_max[i])) m_stall[i]++;
            if (fl) begin
                m_cnt[i]    = 0;
                m_bubble[i] = 1'b1;
            end else begin
                m_cnt[i] = m_cnt[i] + int'(push_e[i]) - int'(pop_e[i]);
                if (push_e[i]) m_bubble[i] = 1'b0;
            end
        end
    endtask

    // Async reset asserted between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0; flush = 1'b0; freeze = 1'b0;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_out_valid", i, 32'(dut_valid[i]), 32'd0);
            check("rst_occupancy", i, 32'(dut_occ[i]), 32'd0);
            check("rst_stall_cnt", i, 32'(dut_stall[i]), 32'd0);
            check("rst_out_data", i, dut_data[i], 32'd0);
            m_cnt[i] = 0; m_stall[i] = 0; m_bubble[i] = 1'b1;
            sb_rd[i] = sb_wr[i];
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        run = 1'b1;
    endtask

    // Monitor: compare observable outputs each cycle and score every pop against the queue.
    always @(negedge clk) begin
        if (run && rst) begin
            for (int i = 0; i < 2; i++) begin
                check("in_ready", i, 32'(dut_ready[i]), 32'(exp_ready[i]));
                check("out_valid", i, 32'(dut_valid[i]), 32'(exp_valid[i]));
                check("occupancy", i, 32'(dut_occ[i]), 32'(exp_occ[i]));
                check("stall_cnt", i, 32'(dut_stall[i]), 32'(exp_stall[i]));
                if (!exp_valid[i] && exp_bubble[i]) check("bubble_data", i, dut_data[i], 32'd0);
                if (dut_valid[i] && out_ready && !freeze && !flush) begin
                    if (sb_rd[i] == sb_wr[i]) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_pop dut%0d: got data 0x%0h expected no entry", i, dut_data[i]);
                    end else begin
                        check("out_data", i, dut_data[i], sb_mem[i][sb_rd[i] % 64]);
                        sb_rd[i]++;
                    end
                end
            end
        end
    end

    initial begin
        cap[0] = 2; cap[1] = 1;
        stall_max[0] = 15; stall_max[1] = 65535;
        rst = 1'b1;
        in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0; flush = 1'b0; freeze = 1'b0;
        #2;
        do_reset();

        // Single push with out_ready high, visible next cycle.
        step(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Fill to two with downstream stalled, then drain in order.
        step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Flush while full drops the simultaneous push and leaves a zero bubble.
        step(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Freeze holds the head for three cycles despite out_ready.
        step(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h99, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h99, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h99, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Streaming at full rate through both variants.
        for (int n = 0; n < 8; n++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Long hold saturates the 4-bit counter, then reset strikes mid-hold.
        step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 20; n++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 32'hBEEF_0002, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic with occasional flush, freeze and a reset.
        for (int n = 0; n < 1500; n++) begin
            step(($urandom % 4) != 0, $urandom, ($urandom % 10) < 7,
                 ($urandom % 16) == 0, ($urandom % 8) == 0);
            if (n == 700) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
